// File: rtl/fc_weight_mem.sv
// fc_weight_mem
//
// Single-port, row-wide weight store for the squeeze-excitation FC layers.
// Each row packs NUM_INSTANCES signed weights (weight k at
// [k*Data_Width +: Data_Width]). The bits are opaque here; there is no sign handling.
// The array has no reset, so it can map onto block RAM. The read port is
// registered, read-first, and has one cycle of latency.
//
// Ports
//   clk      : clock; all activity happens on the rising edge
//   rst      : asynchronous active-high reset; clears data_out and blocks access
//   en       : block enable; gates both read and write
//   wr       : write strobe   (mem[index] <= data_in)
//   rd       : read strobe    (data_out  <= mem[index])
//   index    : row address; rows at DEPTH and above read as zero and ignore writes
//   data_in  : write row
//   data_out : registered read row; holds its value until the next enabled read
module fc_weight_mem #(
  parameter int Data_Width    = 14,
  parameter int NUM_INSTANCES = 32,
  parameter int ADDR_WIDTH    = 15,
  parameter int DEPTH         = 32768
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                wr,
  input  logic                                rd,
  input  logic [ADDR_WIDTH-1:0]               index,
  input  logic [NUM_INSTANCES*Data_Width-1:0] data_in,
  output logic [NUM_INSTANCES*Data_Width-1:0] data_out
);

  localparam int ROW_W  = NUM_INSTANCES * Data_Width;
  // Array address width. This can be narrower than ADDR_WIDTH when DEPTH is
  // smaller than the address space.
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ROW_W-1:0]  mem [DEPTH];
  logic              in_range;
  logic [MEM_AW-1:0] addr;
  logic              do_wr;
  logic              do_rd;

  assign in_range = ({1'b0, index} < DEPTH_L);
  assign addr     = index[MEM_AW-1:0];

  // Out-of-range writes are dropped here rather than aliased onto the low
  // address bits. No access is allowed while reset is held.
  assign do_wr = en & wr & ~rst & in_range;
  assign do_rd = en & rd;

  // Array write port. No reset, so the array can be inferred as RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[addr] <= data_in;
    end
  end

  // Registered read port. This always block samples mem before the write
  // lands on the same edge, which gives read-first behaviour on a same-row
  // collision. Out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (do_rd) begin
      data_out <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_fc_weight_mem.sv
// tb_fc_weight_mem
//
// Self-checking bench for fc_weight_mem. It uses a default-sized instance plus a
// DEPTH=1024 instance for the out-of-range cases. The expected read data comes
// from associative-array models of the row store.
module tb_fc_weight_mem;

  localparam int DW     = 14;
  localparam int NI     = 32;
  localparam int AW     = 15;
  localparam int DEPTH  = 32768;
  localparam int SDEPTH = 1024;
  localparam int RW     = DW * NI;

  typedef logic [RW-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [AW-1:0] index = '0;
  row_t          data_in = '0;
  row_t          data_out;

  logic          s_en = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic [AW-1:0] s_index = '0;
  row_t          s_data_in = '0;
  row_t          s_data_out;

  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;
  row_t model   [int];
  row_t s_model [int];
  row_t exp_out   = '0;
  row_t s_exp_out = '0;

  always #5 clk = ~clk;

  fc_weight_mem #(
    .Data_Width(DW), .NUM_INSTANCES(NI), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .rd(rd),
    .index(index), .data_in(data_in), .data_out(data_out)
  );

  fc_weight_mem #(
    .Data_Width(DW), .NUM_INSTANCES(NI), .ADDR_WIDTH(AW), .DEPTH(SDEPTH)
  ) dut_small (
    .clk(clk), .rst(rst), .en(s_en), .wr(s_wr), .rd(s_rd),
    .index(s_index), .data_in(s_data_in), .data_out(s_data_out)
  );

  task automatic check(input string tag, input row_t got, input row_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic row_t pattern(input int r);
    row_t p;
    for (int k = 0; k < NI; k++) p[k*DW +: DW] = DW'((r * 32 + k) % 8192);
    return p;
  endfunction

  function automatic row_t rand_row();
    row_t x;
    for (int i = 0; i < RW / 32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // One clock on the full-size instance: drive the inputs, take the edge, then
  // update the model. The read is resolved before the write, which gives
  // read-first behaviour.
  task automatic cyc(input bit e, input bit w, input bit r, input int idx,
                     input row_t d, input string tag, input bit chk);
    en = e; wr = w; rd = r; index = AW'(idx); data_in = d;
    @(posedge clk); #1;
    txn++;
    if (e && r) exp_out = (idx < DEPTH && model.exists(idx)) ? model[idx] : '0;
    if (e && w && idx < DEPTH) model[idx] = d;
    $display("txn %0d big en=%0b wr=%0b rd=%0b idx=%0d", txn, e, w, r, idx);
    if (chk) check(tag, data_out, exp_out);
  endtask

  task automatic s_cyc(input bit e, input bit w, input bit r, input int idx,
                       input row_t d, input string tag, input bit chk);
    s_en = e; s_wr = w; s_rd = r; s_index = AW'(idx); s_data_in = d;
    @(posedge clk); #1;
    txn++;
    if (e && r) s_exp_out = (idx < SDEPTH && s_model.exists(idx)) ? s_model[idx] : '0;
    if (e && w && idx < SDEPTH) s_model[idx] = d;
    $display("txn %0d small en=%0b wr=%0b rd=%0b idx=%0d", txn, e, w, r, idx);
    if (chk) check(tag, s_data_out, s_exp_out);
    s_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    row_t a_row, b_row, neg_row;
    int   ridx;

    // Power-up reset
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_big", data_out, '0);
    check("reset_small", s_data_out, '0);
    rst = 1'b0;
    exp_out = '0;

    // Sequential load, then back-to-back readback
    for (int r = 0; r < 64; r++) cyc(1, 1, 0, r, pattern(r), "", 0);
    for (int r = 0; r < 64; r++) cyc(1, 0, 1, r, '0, "seq_read", 1);

    // Asynchronous reset mid-cycle. A write held across the reset edge must not land.
    en = 1'b1; wr = 1'b1; rd = 1'b1; index = AW'(5); data_in = '1;
    #3 rst = 1'b1;
    #1;
    check("async_reset", data_out, '0);
    exp_out = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 0, 1, 5, '0, "row5_after_reset", 1);

    // Enable gating
    cyc(0, 1, 0, 3, '1, "", 0);
    cyc(0, 0, 1, 3, '0, "en0_read_holds", 1);
    cyc(1, 0, 1, 3, '0, "row3_unchanged", 1);

    // Same-row read/write collision (read-first)
    a_row = pattern(7);
    b_row = rand_row();
    check("row7_model_a", model[7], a_row);
    cyc(1, 1, 1, 7, b_row, "rw_collision_old", 1);
    check("rw_collision_is_a", data_out, a_row);
    cyc(1, 0, 1, 7, '0, "rw_collision_new", 1);

    // Boundary rows
    cyc(1, 1, 0, 0, rand_row(), "", 0);
    cyc(1, 1, 0, 32767, rand_row(), "", 0);
    cyc(1, 0, 1, 32767, '0, "row_32767", 1);
    cyc(1, 0, 1, 0, '0, "row_0_after_32767", 1);
    cyc(1, 0, 1, 32767, '0, "row_32767_again", 1);

    // Negative lanes, then hold with rd low for 10 cycles
    for (int k = 0; k < NI; k++) neg_row[k*DW +: DW] = (k % 2 == 0) ? 14'h3FFF : 14'h2000;
    cyc(1, 1, 0, 100, neg_row, "", 0);
    cyc(1, 0, 1, 100, '0, "neg_read", 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, $urandom_range(0, 63), '0, "hold_rd_low", 1);
      check("hold_bits", data_out, neg_row);
    end

    // Randomized mix over the rows that have already been written
    for (int i = 0; i < 200; i++) begin
      ridx = $urandom_range(0, 65);
      if (ridx == 64) ridx = 32767;
      else if (ridx == 65) ridx = 100;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, ridx, rand_row(), "random", 1);
    end
    en = 1'b0; wr = 1'b0; rd = 1'b0;

    // DEPTH=1024 instance: index 2000 is out of range and must not alias to 976
    s_cyc(1, 1, 0, 976, pattern(976), "", 0);
    s_cyc(1, 1, 0, 0, pattern(1), "", 0);
    s_cyc(1, 1, 0, 1023, pattern(1023), "", 0);
    s_cyc(1, 0, 1, 976, '0, "small_976_before", 1);
    s_cyc(1, 1, 0, 2000, '1, "", 0);
    s_cyc(1, 0, 1, 2000, '0, "small_oor_read", 1);
    check("small_oor_zero", s_data_out, '0);
    s_cyc(1, 0, 1, 976, '0, "small_976_kept", 1);
    s_cyc(1, 0, 1, 0, '0, "small_0_kept", 1);
    s_cyc(1, 0, 1, 1023, '0, "small_1023_kept", 1);
    s_cyc(1, 1, 1, 2000, '1, "small_oor_rw", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_weight_mem.md
# fc_weight_mem

Single-port, row-wide weight store for the fully-connected (squeeze-excitation) layers of the MobileNetV3 accelerator. Each row holds one burst of `NUM_INSTANCES` signed weights feeding the SE block's multiplier array in parallel. The loader writes rows sequentially at bring-up, then the SE block drives `rd` and `index` from its weight-address generator. Reads are synchronous with one cycle of latency.

## Interface
**Parameters**
- `Data_Width`, 14: width of one signed weight, Q(Data_Width-FBITS).FBITS, opaque to this block.
- `NUM_INSTANCES`, 32: weights per row; the row width is `NUM_INSTANCES*Data_Width` (448 bits by default).
- `ADDR_WIDTH`, 15: width of the row index.
- `DEPTH`, 32768: number of rows; must be `<= 2**ADDR_WIDTH`.

**Ports**
- `clk`, input, 1: single clock; all activity on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `en`, input, 1: block enable; gates both read and write.
- `wr`, input, 1: write strobe.
- `rd`, input, 1: read strobe.
- `index`, input, `ADDR_WIDTH`: row address.
- `data_in`, input, `NUM_INSTANCES*Data_Width`: write row; weight k is at `[k*Data_Width +: Data_Width]`.
- `data_out`, output, `NUM_INSTANCES*Data_Width`: registered read row, using the same lane packing as `data_in`.

## Operation
- Storage is an array of `DEPTH` rows, each `NUM_INSTANCES*Data_Width` bits. It is inferable as block RAM and has no reset on the array.
- **Write:** at a rising edge with `en=1` and `wr=1`, `mem[index] <= data_in`. The full row is written; there are no lane masks.
- **Read:** at a rising edge with `en=1` and `rd=1`, `data_out <= mem[index]`.
- **Simultaneous read and write** (`en=1`, `wr=1`, `rd=1`):
  - Both operations are performed.
  - Read-first: `data_out` returns the content before the write, including when both target the same row.
- **Disabled** (`en=0`): no write, no read. `data_out` holds its value and `wr`/`rd` are ignored.
- **No read** (`en=1`, `rd=0`): `data_out` holds its last value. It is never cleared by idle cycles.
- **Addressing:**
  - `index >= DEPTH` is out of range. Writes are dropped and reads return all-zero.
  - With default parameters every index from 0 to 32767 is valid.
  - There is no internal address counter; index wrap from 32767 to 0 is the driver's responsibility.
- **Reset:**
  - Asserting `rst` forces `data_out` to 0 immediately and asynchronously.
  - Array contents are unaffected by reset.
  - While `rst=1`, no reads or writes occur.
  - A read issued in the cycle of reset deassertion is honoured at the next rising edge.
- Data is treated as raw bits; there is no sign handling.

## Timing
- Write latency is 1 edge. Data written at edge N is readable by a read issued at edge N+1.
- Read latency is 1 cycle. `rd`/`index` sampled at edge N produce `data_out` valid after edge N, and it stays stable until the next enabled read or reset.
- Back-to-back reads with a new `index` every cycle are supported at full throughput, one row per cycle.
- The SE block must account for the 1-cycle latency: weights for the address presented at cycle N are consumed at cycle N+1.
- There are no handshake outputs; the block is always ready.
- Reset values: `data_out = 0`. The array is undefined until written.

## Test plan
1. **Reset:** drive `rst=1` for one cycle at any time.
   - `data_out` becomes 0 asynchronously, with no wait for an edge.
   - A later read of previously written row 5 still returns its data.
2. **Sequential load and readback:**
   - Write rows 0..63 with lane k of row r = (r*32+k) mod 8192, using `en=1`, `wr=1` and one row per cycle.
   - Then read rows 0..63 back-to-back with `rd=1`.
   - Each `data_out` matches one cycle after its address is presented.
3. **Enable gating:**
   - With `en=0`, `wr=1`, `index=3`, `data_in=all-ones`: row 3 is unchanged.
   - With `en=0`, `rd=1`: `data_out` holds its previous row.
4. **Simultaneous read/write on the same row:**
   - Row 7 holds A; issue `wr=1`, `rd=1`, `index=7`, `data_in=B`.
   - `data_out=A` after that edge; the next read of row 7 returns B.
5. **Boundaries:**
   - Write and read rows 0 and 32767: both are correct and independent.
   - Driving `index=0` after 32767 reads row 0.
   - With `DEPTH=1024`, writing `index=2000` leaves all rows unchanged and reading `index=2000` returns 0.
6. **Hold and negative values:**
   - Read a row whose lanes are -1 (0x3FFF) and -8192 (0x2000), then deassert `rd` for 10 cycles.
   - `data_out` is unchanged bit-for-bit throughout.
